// File: rtl/operand_select_stage_if.sv
// operand_select_stage_if: bundles both operand sources, the mux select and the MAC-side output port.
interface operand_select_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic             sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] xfer_count;

    modport master (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, sel, out_data, out_valid, xfer_count
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, sel, out_data, out_valid, xfer_count
    );
endinterface

// File: rtl/operand_select_stage.sv
// operand_select_stage: round-robin burst arbiter over two operand streams feeding a 2-entry skid buffer.
module operand_select_stage #(
    parameter int WIDTH = 32,
    parameter int BURST = 4,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    operand_select_stage_if.slave io
);
    typedef enum logic [1:0] {IDLE, SRC_A, SRC_B} state_t;

    state_t           r_state;
    logic             r_sel;
    logic             r_last_a;
    logic [3:0]       r_burst;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;
    logic [CNT_W-1:0] r_xfer;

    state_t           w_state_nxt;
    state_t           w_other;
    logic [3:0]       w_burst_nxt;
    logic             w_push_a;
    logic             w_push_b;
    logic             w_push;
    logic             w_pop;
    logic             w_own_v;
    logic             w_oth_v;
    logic [WIDTH-1:0] w_din;

    assign io.a_ready    = (r_state == SRC_A) && (r_cnt != 2'd2);
    assign io.b_ready    = (r_state == SRC_B) && (r_cnt != 2'd2);
    assign io.sel        = r_sel;
    assign io.out_data   = r_buf0;
    assign io.out_valid  = r_cnt != 2'd0;
    assign io.xfer_count = r_xfer;

    assign w_push_a = io.a_valid & io.a_ready;
    assign w_push_b = io.b_valid & io.b_ready;
    assign w_push   = w_push_a | w_push_b;
    assign w_pop    = io.out_valid & io.out_ready;
    assign w_din    = w_push_a ? io.a_data : io.b_data;
    assign w_own_v  = (r_state == SRC_A) ? io.a_valid : io.b_valid;
    assign w_oth_v  = (r_state == SRC_A) ? io.b_valid : io.a_valid;
    assign w_other  = (r_state == SRC_A) ? SRC_B : SRC_A;

    // A full burst only yields when the other side is actually waiting.
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst;
        if (r_state == IDLE) begin
            if (io.a_valid && io.b_valid) w_state_nxt = r_last_a ? SRC_B : SRC_A;
            else if (io.a_valid) w_state_nxt = SRC_A;
            else if (io.b_valid) w_state_nxt = SRC_B;
        end else if (!w_own_v) begin
            w_state_nxt = w_oth_v ? w_other : IDLE;
            w_burst_nxt = 4'd0;
        end else if (w_push) begin
            w_burst_nxt = r_burst + 4'd1;
            if (r_burst + 4'd1 == 4'(BURST)) begin
                w_burst_nxt = 4'd0;
                if (w_oth_v) w_state_nxt = w_other;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= 1'b0;
            r_last_a <= 1'b0;
            r_burst  <= 4'd0;
            r_cnt    <= 2'd0;
            r_buf0   <= '0;
            r_buf1   <= '0;
            r_xfer   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= (w_state_nxt == SRC_A) ? 1'b1 : (w_state_nxt == SRC_B) ? 1'b0 : r_sel;
            r_last_a <= w_push ? w_push_a : r_last_a;
            r_burst  <= w_burst_nxt;
            r_cnt    <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))) r_buf0 <= w_din;
            else if (w_pop && r_cnt == 2'd2) r_buf0 <= r_buf1;
            if (w_push && r_cnt == 2'd1 && !w_pop) r_buf1 <= w_din;
            if (w_pop) r_xfer <= r_xfer + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_operand_select_stage.sv
// tb_operand_select_stage: random and directed traffic against a queue-based arbitration model.
module tb_operand_select_stage;
    localparam int BURST = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    operand_select_stage_if #(.WIDTH(32), .CNT_W(CNT_W)) io ();

    operand_select_stage #(.WIDTH(32), .BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    // owner: 0 none, 1 A, 2 B; last: source of the most recent accepted word
    int          m_owner, m_last, m_run, m_xfer, m_sel;
    int          na = 0, nb = 0;
    logic [31:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_run = 0; m_xfer = 0; m_sel = 0;
        m_q.delete();
    endtask

    task automatic model_check();
        check("a_ready", 32'(io.a_ready), 32'(m_owner == 1 && m_q.size() < 2));
        check("b_ready", 32'(io.b_ready), 32'(m_owner == 2 && m_q.size() < 2));
        check("sel", 32'(io.sel), 32'(m_sel));
        check("out_valid", 32'(io.out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("out_data", io.out_data, m_q[0]);
        check("xfer_count", 32'(io.xfer_count), 32'(m_xfer));
    endtask

    task automatic model_step(input bit av, input bit bv, input bit ordy);
        bit pop, pa, pb, own_v, oth_v;
        pop = m_q.size() > 0 && ordy;
        pa  = m_owner == 1 && m_q.size() < 2 && av;
        pb  = m_owner == 2 && m_q.size() < 2 && bv;
        if (pop) void'(m_q.pop_front());
        if (pa) begin m_q.push_back(32'hA000_0000 + 32'(na)); na++; end
        if (pb) begin m_q.push_back(32'hB000_0000 + 32'(nb)); nb++; end
        m_xfer = (m_xfer + int'(pop)) % (1 << CNT_W);
        if (m_owner == 0) begin
            if (av && bv) m_owner = (m_last == 1) ? 2 : 1;
            else if (av) m_owner = 1;
            else if (bv) m_owner = 2;
        end else begin
            own_v = (m_owner == 1) ? av : bv;
            oth_v = (m_owner == 1) ? bv : av;
            if (!own_v) begin
                m_owner = oth_v ? 3 - m_owner : 0;
                m_run = 0;
            end else if (pa || pb) begin
                m_last = m_owner;
                m_run++;
                if (m_run == BURST) begin
                    m_run = 0;
                    if (oth_v) m_owner = 3 - m_owner;
                end
            end
        end
        if (m_owner != 0) m_sel = (m_owner == 1) ? 1 : 0;
    endtask

    task automatic run(input int cycles, input int pa, input int pb, input int pr);
        bit av, bv, ordy;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            model_check();
            av = $urandom_range(99) < pa;
            bv = $urandom_range(99) < pb;
            ordy = $urandom_range(99) < pr;
            io.a_valid = av;
            io.b_valid = bv;
            io.out_ready = ordy;
            io.a_data = 32'hA000_0000 + 32'(na);
            io.b_data = 32'hB000_0000 + 32'(nb);
            model_step(av, bv, ordy);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        model_check();
        io.a_valid = 1'b0;
        io.b_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_xfer", 32'(io.xfer_count), 32'd0);
        check("rst_sel", 32'(io.sel), 32'd0);
        check("rst_a_ready", 32'(io.a_ready), 32'd0);
        check("rst_b_ready", 32'(io.b_ready), 32'd0);
        check("rst_out_data", io.out_data, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        io.a_valid = 1'b0;
        io.b_valid = 1'b0;
        io.out_ready = 1'b0;
        io.a_data = '0;
        io.b_data = '0;
        model_reset();
        #12;
        check("init_out_valid", 32'(io.out_valid), 32'd0);
        check("init_out_data", io.out_data, 32'd0);
        check("init_xfer", 32'(io.xfer_count), 32'd0);
        check("init_sel", 32'(io.sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(20, 100, 0, 100);
        run(40, 100, 100, 100);
        run(10, 100, 0, 0);
        run(6, 100, 0, 100);
        run(8, 0, 100, 0);
        async_reset();
        run(30, 100, 100, 100);
        run(20, 100, 100, 30);
        async_reset();
        run(3000, 70, 70, 70);
        run(1000, 50, 30, 50);
        run(1000, 95, 95, 95);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
